// File: rtl/sopc_run_ctrl.sv
// sopc_run_ctrl: run controller for the minimal RISC-V SOPC.
// Holds the core in reset for a fixed number of cycles, lets it run while
// counting cycles, and watches data-memory writes for the TOHOST word that
// ends the run as pass, fail (with a code) or timeout. A terminal state can be
// left with restart_req, which re-runs the core without a global reset.
module sopc_run_ctrl #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] TOHOST_ADDR = ADDR_W'(32'h0000_1000),
    parameter int                RST_HOLD    = 16,
    parameter int unsigned       MAX_CYCLES  = 1000,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [30:0]       fail_code,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // hold_cnt only needs to reach RST_HOLD-1
    localparam int                HOLD_W     = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    // Compared in 64 bits so a budget wider than cycle_cnt simply never fires
    localparam logic [63:0]       TIMEOUT_AT = 64'(MAX_CYCLES) - 64'd1;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;

    logic tohost_hit;
    logic pass_hit;
    logic fail_hit;
    logic timeout_hit;

    // Classify the current TOHOST write and whether the cycle budget is spent
    always_comb begin
        tohost_hit  = mem_we && (mem_addr == TOHOST_ADDR);
        pass_hit    = tohost_hit && (mem_wdata == 32'd1);
        fail_hit    = tohost_hit && mem_wdata[0] && (mem_wdata != 32'd1);
        timeout_hit = (MAX_CYCLES != 0) && (64'(cycle_cnt) == TIMEOUT_AT);
    end

    // Run sequencing: hold the core, run it, then freeze in a terminal state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_HOLD;
            hold_cnt  <= '0;
            cycle_cnt <= '0;
            fail_code <= '0;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state    <= ST_RUN;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (pass_hit) begin
                        state <= ST_PASS;
                    end else if (fail_hit) begin
                        state     <= ST_FAIL;
                        fail_code <= mem_wdata[31:1];
                    end else if (timeout_hit) begin
                        state <= ST_TIMEOUT;
                    end else if (cycle_cnt != CNT_MAX) begin
                        cycle_cnt <= cycle_cnt + CNT_W'(1);
                    end
                end
                ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                    if (restart_req) begin
                        state     <= ST_HOLD;
                        hold_cnt  <= '0;
                        cycle_cnt <= '0;
                        fail_code <= '0;
                    end
                end
                default: begin
                    state <= ST_HOLD;
                end
            endcase
        end
    end

    // Status outputs are decoded straight from the state register
    always_comb begin
        core_rst = (state != ST_RUN);
        running  = (state == ST_RUN);
        pass     = (state == ST_PASS);
        timeout  = (state == ST_TIMEOUT);
        done     = (state == ST_PASS) || (state == ST_FAIL) || (state == ST_TIMEOUT);
    end

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// tb_sopc_run_ctrl: bench for sopc_run_ctrl.
// Two instances share one stimulus stream: instance A (RST_HOLD=16,
// MAX_CYCLES=100, 32-bit counter) and instance B (RST_HOLD=3, timeout
// disabled, 8-bit counter). A directed table checks A against hand-derived
// values, and a reference model of the run rules checks both every cycle.
module tb_sopc_run_ctrl;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        restart_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        a_core_rst, a_running, a_done, a_pass, a_timeout;
    logic [30:0] a_fail_code;
    logic [31:0] a_cycle_cnt;

    logic        b_core_rst, b_running, b_done, b_pass, b_timeout;
    logic [30:0] b_fail_code;
    logic [7:0]  b_cycle_cnt;

    int passCount  = 0;
    int totalCount = 0;

    sopc_run_ctrl #(
        .ADDR_W     (32),
        .TOHOST_ADDR(TOHOST),
        .RST_HOLD   (16),
        .MAX_CYCLES (100),
        .CNT_W      (32)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .restart_req(restart_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (a_core_rst),
        .running    (a_running),
        .done       (a_done),
        .pass       (a_pass),
        .timeout    (a_timeout),
        .fail_code  (a_fail_code),
        .cycle_cnt  (a_cycle_cnt)
    );

    sopc_run_ctrl #(
        .ADDR_W     (32),
        .TOHOST_ADDR(TOHOST),
        .RST_HOLD   (3),
        .MAX_CYCLES (0),
        .CNT_W      (8)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .restart_req(restart_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst   (b_core_rst),
        .running    (b_running),
        .done       (b_done),
        .pass       (b_pass),
        .timeout    (b_timeout),
        .fail_code  (b_fail_code),
        .cycle_cnt  (b_cycle_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        core_rst;
        logic        running;
        logic        done;
        logic        pass;
        logic        timeout;
        logic [30:0] fail_code;
        logic [31:0] cycle_cnt;
    } obs_t;

    // Reference model: how far into the hold we are, whether the run ended
    // and how, and the true (unsaturated) number of run cycles
    typedef struct {
        int          holdElapsed;
        bit          ended;
        int          outcome;     // 0 none, 1 pass, 2 fail, 3 timeout
        longint      runCycles;
        logic [30:0] code;
    } mdl_t;

    mdl_t   mdl [2];
    int     pHold [2] = '{16, 3};
    longint pMax  [2] = '{100, 0};
    int     pCntW [2] = '{32, 8};

    typedef struct {
        bit          rst;
        bit          restart;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cycles;
        obs_t        exp;
    } vec_t;

    vec_t tbl [$];

    function automatic longint satCnt(longint v, int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic void clearModel(int i);
        mdl[i].holdElapsed = 0;
        mdl[i].ended       = 1'b0;
        mdl[i].outcome     = 0;
        mdl[i].runCycles   = 0;
        mdl[i].code        = '0;
    endfunction

    // Advance the model by one clock edge using the inputs now being driven
    function automatic void stepModel(int i);
        bit hit;
        hit = mem_we && (mem_addr == TOHOST);
        if (rst) begin
            clearModel(i);
        end else if (mdl[i].ended) begin
            if (restart_req) clearModel(i);
        end else if (mdl[i].holdElapsed < pHold[i]) begin
            mdl[i].holdElapsed++;
        end else if (hit && mem_wdata == 32'd1) begin
            mdl[i].ended   = 1'b1;
            mdl[i].outcome = 1;
        end else if (hit && mem_wdata[0]) begin
            mdl[i].ended   = 1'b1;
            mdl[i].outcome = 2;
            mdl[i].code    = mem_wdata[31:1];
        end else if (pMax[i] != 0 && satCnt(mdl[i].runCycles, pCntW[i]) == pMax[i] - 1) begin
            mdl[i].ended   = 1'b1;
            mdl[i].outcome = 3;
        end else begin
            mdl[i].runCycles++;
        end
    endfunction

    function automatic obs_t expObs(int i);
        obs_t o;
        o.running   = !mdl[i].ended && (mdl[i].holdElapsed == pHold[i]);
        o.core_rst  = !o.running;
        o.done      = mdl[i].ended;
        o.pass      = (mdl[i].outcome == 1);
        o.timeout   = (mdl[i].outcome == 3);
        o.fail_code = mdl[i].code;
        o.cycle_cnt = 32'(satCnt(mdl[i].runCycles, pCntW[i]));
        return o;
    endfunction

    function automatic obs_t getObs(int i);
        obs_t o;
        if (i == 0) o = {a_core_rst, a_running, a_done, a_pass, a_timeout, a_fail_code, a_cycle_cnt};
        else        o = {b_core_rst, b_running, b_done, b_pass, b_timeout, b_fail_code, 24'd0, b_cycle_cnt};
        return o;
    endfunction

    function automatic vec_t mk(bit r, bit rs, bit we, logic [31:0] ad, logic [31:0] wd, int n,
                                bit ecr, bit erun, bit edone, bit epass, bit eto,
                                logic [30:0] ecode, logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.restart = rs; v.we = we; v.addr = ad; v.wdata = wd; v.cycles = n;
        v.exp = {ecr, erun, edone, epass, eto, ecode, ecnt};
        return v;
    endfunction

    task automatic applyStimulus(bit r, bit rs, bit we, logic [31:0] ad, logic [31:0] wd);
        rst         = r;
        restart_req = rs;
        mem_we      = we;
        mem_addr    = ad;
        mem_wdata   = wd;
    endtask

    task automatic checkOutput(string name, obs_t act, obs_t exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s @%0t: got core_rst=%b running=%b done=%b pass=%b timeout=%b fail_code=%h cycle_cnt=%0d; required core_rst=%b running=%b done=%b pass=%b timeout=%b fail_code=%h cycle_cnt=%0d",
                     name, $time, act.core_rst, act.running, act.done, act.pass, act.timeout,
                     act.fail_code, act.cycle_cnt, exp.core_rst, exp.running, exp.done,
                     exp.pass, exp.timeout, exp.fail_code, exp.cycle_cnt);
        end
    endtask

    task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    // One clock: model follows the driven inputs, both instances checked after the edge
    task automatic tick();
        stepModel(0);
        stepModel(1);
        @(posedge clk);
        #1;
        checkOutput("modelA", getObs(0), expObs(0));
        checkOutput("modelB", getObs(1), expObs(1));
    endtask

    // Directed table, saturation/no-timeout run, then random traffic
    initial begin
        clearModel(0);
        clearModel(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        //               rst rs we addr         wdata          n    crst run done pass to code          cnt
        tbl.push_back(mk(1, 0, 0, 32'h0,      32'h0,          5,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          15,  1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          1,   0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          37,  0,  1,  0,   0,   0, 31'd0,        32'd37));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'h1,          1,   1,  0,  1,   1,   0, 31'd0,        32'd37));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          5,   1,  0,  1,   1,   0, 31'd0,        32'd37));
        tbl.push_back(mk(0, 1, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          16,  0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          10,  0,  1,  0,   0,   0, 31'd0,        32'd10));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'hB,          1,   1,  0,  1,   0,   0, 31'd5,        32'd10));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'h1,          1,   1,  0,  1,   0,   0, 31'd5,        32'd10));
        tbl.push_back(mk(0, 1, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          16,  0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'h2,          1,   0,  1,  0,   0,   0, 31'd0,        32'd1));
        tbl.push_back(mk(0, 0, 1, 32'h1004,   32'h3,          1,   0,  1,  0,   0,   0, 31'd0,        32'd2));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          97,  0,  1,  0,   0,   0, 31'd0,        32'd99));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          1,   1,  0,  1,   0,   1, 31'd0,        32'd99));
        tbl.push_back(mk(0, 1, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          16,  0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          99,  0,  1,  0,   0,   0, 31'd0,        32'd99));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'h1,          1,   1,  0,  1,   1,   0, 31'd0,        32'd99));
        tbl.push_back(mk(0, 1, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'h1,          16,  0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          20,  0,  1,  0,   0,   0, 31'd0,        32'd20));
        tbl.push_back(mk(0, 1, 0, 32'h0,      32'h0,          1,   0,  1,  0,   0,   0, 31'd0,        32'd21));
        tbl.push_back(mk(1, 0, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 0, 32'h0,      32'h0,          16,  0,  1,  0,   0,   0, 31'd0,        32'd0));
        tbl.push_back(mk(0, 0, 1, TOHOST,     32'hFFFF_FFFF,  1,   1,  0,  1,   0,   0, 31'h7FFF_FFFF, 32'd0));
        tbl.push_back(mk(1, 0, 0, 32'h0,      32'h0,          1,   1,  0,  0,   0,   0, 31'd0,        32'd0));

        for (int v = 0; v < tbl.size(); v++) begin
            applyStimulus(tbl[v].rst, tbl[v].restart, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            for (int c = 0; c < tbl[v].cycles; c++) tick();
            checkOutput($sformatf("vec%0d", v), getObs(0), tbl[v].exp);
        end

        // Long run: B never times out and its 8-bit counter saturates; A times out
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 10000; c++) tick();
        checkValue("satB_cycle_cnt", 32'(b_cycle_cnt), 32'd255);
        checkValue("satB_running",   32'(b_running),   32'd1);
        checkValue("satB_timeout",   32'(b_timeout),   32'd0);
        checkValue("longA_timeout",  32'(a_timeout),   32'd1);
        checkValue("longA_cycle_cnt", a_cycle_cnt,     32'd99);

        // Random traffic checked cycle by cycle against the model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] wd;
            logic [31:0] ad;
            int          k;
            k  = $urandom_range(0, 3);
            wd = $urandom;
            if (k == 0)      wd = 32'h1;
            else if (k == 1) wd[0] = 1'b1;
            else             wd[0] = 1'b0;
            ad = ($urandom_range(0, 1) == 1) ? TOHOST : 32'h0000_1004;
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                          $urandom_range(0, 31) == 0, ad, wd);
            tick();
        end

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
